gear_shift_loop_filter: RTL and testbench
=========================================

Name: gear_shift_loop_filter

Overview:
- Second-generation digital PI loop filter for the ADPLL: converts signed phase/frequency error samples into an unsigned DCO control code.
- Adds gain gear-shifting (acquire/track gain sets), lock detection, saturation with anti-windup, a hold mode and a valid handshake.
- Sits between the phase detector/TDC and the DCO, clocked by the generated clock.

Parameters:
- ERROR_WIDTH, 8, signed error input width
- DCO_CC_WIDTH, 9, unsigned DCO control code width; midscale MID = 2^(DCO_CC_WIDTH-1)
- KP_WIDTH, 6, proportional gain width, unsigned
- KP_FRAC_WIDTH, 4, fractional bits of KP
- KI_WIDTH, 8, integral gain width, unsigned
- KI_FRAC_WIDTH, 7, fractional bits of KI and of the integrator
- KP_ACQ / KI_ACQ, 6'b010000 / 8'b00010000, acquire gains (1.0 / 0.125)
- KP_TRK / KI_TRK, 6'b001000 / 8'b00000100, track gains (0.5 / 0.03125)
- LOCK_THRESH, 2, |error| <= LOCK_THRESH counts as in-window
- LOCK_COUNT, 16, consecutive in-window samples needed per gear advance
- UNLOCK_COUNT, 4, consecutive out-of-window samples that force re-acquire

Ports:
- gen_clk_i  in  1  filter clock
- reset_n_i  in  1  asynchronous, active-low reset
- enable_i  in  1  filter enable; low returns to IDLE
- hold_i  in  1  freeze integrator and lock counters
- error_i  in  ERROR_WIDTH  signed error sample
- error_valid_i  in  1  error_i valid this cycle
- dco_cc_o  out  DCO_CC_WIDTH  unsigned DCO code
- dco_cc_valid_o  out  1  one-cycle pulse when dco_cc_o updates
- state_o  out  2  IDLE=0, ACQUIRE=1, TRACK=2, LOCKED=3
- locked_o  out  1  high only in LOCKED

Behaviour:
- Reset: dco_cc_o=MID, dco_cc_valid_o=0, state_o=IDLE, locked_o=0, integrator=0, counters=0.
- IDLE: same values as reset; enable_i high -> ACQUIRE next cycle.
- Per accepted sample (error_valid_i=1, state!=IDLE):
  - I[n] = sat(I[n-1] + KI*e[n]);
  - P = (KP*e[n]) >>> KP_FRAC_WIDTH (arithmetic, floor);
  - sum = MID + P + I[n], floor to integer, clamp to [0, 2^DCO_CC_WIDTH-1].
- Latency: dco_cc_o and dco_cc_valid_o update on the edge after the accepted sample (1 cycle).
- Integrator: signed, DCO_CC_WIDTH+1 integer bits plus KI_FRAC_WIDTH fraction; saturates at ±MID.
- Anti-windup: if the previous output was clamped high (low) and e[n]>0 (<0), the integrator is not updated.
- Gains: ACQUIRE uses KP_ACQ/KI_ACQ; TRACK and LOCKED use KP_TRK/KI_TRK. Integrator is preserved across gear changes; the P-term step is allowed.
- Lock counters, updated per accepted sample:
  - in-window count increments, out-window count clears, and vice versa;
  - ACQUIRE: in-count reaches LOCK_COUNT -> TRACK, counters cleared;
  - TRACK: in-count reaches LOCK_COUNT -> LOCKED, locked_o=1; out-count reaches UNLOCK_COUNT -> ACQUIRE;
  - LOCKED: out-count reaches UNLOCK_COUNT -> ACQUIRE, locked_o=0 on the same edge.
- hold_i=1: integrator and counters frozen. Accepted samples still produce outputs (P term plus frozen I).
- enable_i low in any state: IDLE on the next edge, integrator cleared, dco_cc_o=MID, no valid pulse. enable_i dominates hold_i.
- error_valid_i=0: all state holds; dco_cc_valid_o=0.
- Asynchronous reset mid-operation: immediate return to reset values.

Optional Feature:
- Macro GEAR_SHIFT_LOOP_FILTER_DITHER_EN.
- Defined: a first-order error-feedback sigma-delta accumulates the KI_FRAC_WIDTH fractional bits of sum and adds its carry (0/1) to the integer code before clamping, so the long-run average code equals the fractional sum.
- Undefined: fractional bits are truncated (floor). No dither state exists.

Decomposition:
- Package loop_filter_pkg: state enum (IDLE/ACQUIRE/TRACK/LOCKED), 2-bit state width, the accumulator-width localparam function, and the saturate helper function.
- Sub-module lock_detector: window compare, in/out counters, FSM, locked_o and gear select. The parent keeps the PI datapath and clamp.

Test Plan:
- Reset, enable=1, error=10 constant (defaults, no dither) -> dco_cc_o 267 then 268 on successive valid pulses; each pulse one cycle after the sample.
- error=+127 constant -> dco_cc_o reaches 511 and stays. Switching to error=-1 -> dco_cc_o <511 on the very next valid pulse (no windup).
- error=0 for 16 samples -> state_o=TRACK. 16 more -> LOCKED, locked_o=1. Then error=20 for 4 samples -> ACQUIRE, locked_o=0.
- In TRACK, pattern of 15 in-window, 1 out-window, 15 in-window -> stays in TRACK (counter cleared by the miss).
- hold_i=1 with error=10 -> the integrator term stays frozen and dco_cc_o changes only by the P term. Deassert enable_i mid-stream -> dco_cc_o=256, state_o=IDLE next cycle.
- With DITHER_EN and a fixed sum of 256.5 (integrator preloaded via the stimulus sequence, then error=0) -> dco_cc_o alternates 256/257 with a mean of 256.5 over 64 samples.

Source files
------------

// File: rtl/loop_filter_pkg.sv
// Shared types and helpers for the gear-shift PI loop filter.
// State encoding, integrator width and saturation helper.
package loop_filter_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2,
    LOCKED  = 2'd3
  } lf_state_e;

  function automatic int acc_width(
    input int dco_w,
    input int frac_w
  );
    return dco_w + 1 + frac_w;
  endfunction

  function automatic logic signed [31:0] sat_s32(
    input logic signed [31:0] v,
    input logic signed [31:0] lim
  );
    if (v > lim)
      return lim;
    else if (v < -lim)
      return -lim;
    else
      return v;
  endfunction

endpackage

// File: rtl/lock_detector.sv
// Lock window compare, in/out-window counters and gear FSM.
// Gear select is high in TRACK and LOCKED.
module lock_detector
  import loop_filter_pkg::*;
#(
  parameter int ERROR_WIDTH  = 8,
  parameter int LOCK_THRESH  = 2,
  parameter int LOCK_COUNT   = 16,
  parameter int UNLOCK_COUNT = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          hold,
  input  logic                          sample,
  input  logic signed [ERROR_WIDTH-1:0] error,
  output lf_state_e                     state,
  output logic                          locked,
  output logic                          gear_trk
);

  localparam int CNT_MAX = (LOCK_COUNT > UNLOCK_COUNT) ?
                           LOCK_COUNT : UNLOCK_COUNT;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic signed [ERROR_WIDTH:0] THR =
    (ERROR_WIDTH+1)'(LOCK_THRESH);

  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] out_cnt;
  logic [CNT_W-1:0] in_inc;
  logic [CNT_W-1:0] out_inc;
  logic [CNT_W-1:0] in_nxt;
  logic [CNT_W-1:0] out_nxt;
  logic             in_hit;
  logic             out_hit;
  logic             in_win;
  logic             upd;
  logic signed [ERROR_WIDTH:0] e_x;
  lf_state_e        st_nxt;

  assign e_x      = (ERROR_WIDTH+1)'(error);
  assign in_win   = (e_x <= THR) && (e_x >= -THR);
  assign upd      = sample && !hold && (state != IDLE);
  assign gear_trk = (state == TRACK) || (state == LOCKED);

  always_comb begin
    in_inc  = (in_cnt == CNT_W'(CNT_MAX)) ?
              in_cnt : in_cnt + 1'b1;
    out_inc = (out_cnt == CNT_W'(CNT_MAX)) ?
              out_cnt : out_cnt + 1'b1;
    in_hit  = in_inc >= CNT_W'(LOCK_COUNT);
    out_hit = out_inc >= CNT_W'(UNLOCK_COUNT);
  end

  always_comb begin
    in_nxt  = in_cnt;
    out_nxt = out_cnt;
    st_nxt  = state;
    if (upd) begin
      if (in_win) begin
        in_nxt  = in_inc;
        out_nxt = '0;
      end else begin
        in_nxt  = '0;
        out_nxt = out_inc;
      end
      unique case (state)
        ACQUIRE: if (in_win && in_hit) st_nxt = TRACK;
        TRACK: begin
          if (in_win && in_hit)
            st_nxt = LOCKED;
          else if (!in_win && out_hit)
            st_nxt = ACQUIRE;
        end
        LOCKED: if (!in_win && out_hit) st_nxt = ACQUIRE;
        default: st_nxt = state;
      endcase
      // every gear change restarts both counts
      if (st_nxt != state) begin
        in_nxt  = '0;
        out_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      in_cnt  <= '0;
      out_cnt <= '0;
      locked  <= 1'b0;
    end else if (!enable) begin
      state   <= IDLE;
      in_cnt  <= '0;
      out_cnt <= '0;
      locked  <= 1'b0;
    end else if (state == IDLE) begin
      state <= ACQUIRE;
    end else begin
      state   <= st_nxt;
      in_cnt  <= in_nxt;
      out_cnt <= out_nxt;
      locked  <= (st_nxt == LOCKED);
    end
  end

endmodule

// File: rtl/gear_shift_loop_filter.sv
// Gear-shifting PI loop filter: signed error -> unsigned DCO code.
// GEAR_SHIFT_LOOP_FILTER_DITHER_EN adds sigma-delta dither of the fraction.
module gear_shift_loop_filter
  import loop_filter_pkg::*;
#(
  parameter int ERROR_WIDTH   = 8,
  parameter int DCO_CC_WIDTH  = 9,
  parameter int KP_WIDTH      = 6,
  parameter int KP_FRAC_WIDTH = 4,
  parameter int KI_WIDTH      = 8,
  parameter int KI_FRAC_WIDTH = 7,
  parameter logic [KP_WIDTH-1:0] KP_ACQ = 6'b010000,
  parameter logic [KI_WIDTH-1:0] KI_ACQ = 8'b00010000,
  parameter logic [KP_WIDTH-1:0] KP_TRK = 6'b001000,
  parameter logic [KI_WIDTH-1:0] KI_TRK = 8'b00000100,
  parameter int LOCK_THRESH   = 2,
  parameter int LOCK_COUNT    = 16,
  parameter int UNLOCK_COUNT  = 4
) (
  input  logic                          gen_clk_i,
  input  logic                          reset_n_i,
  input  logic                          enable_i,
  input  logic                          hold_i,
  input  logic signed [ERROR_WIDTH-1:0] error_i,
  input  logic                          error_valid_i,
  output logic [DCO_CC_WIDTH-1:0]       dco_cc_o,
  output logic                          dco_cc_valid_o,
  output logic [STATE_W-1:0]            state_o,
  output logic                          locked_o
);

  localparam int IW = acc_width(DCO_CC_WIDTH, KI_FRAC_WIDTH);
  localparam int FW = KI_FRAC_WIDTH;
  localparam logic signed [31:0] MID_F =
    32'sd1 <<< (DCO_CC_WIDTH - 1 + FW);
  localparam logic signed [31:0] CC_MAX =
    (32'sd1 <<< DCO_CC_WIDTH) - 32'sd1;
  localparam logic [DCO_CC_WIDTH-1:0] MID_CC =
    {1'b1, {(DCO_CC_WIDTH-1){1'b0}}};

  lf_state_e state;
  logic      gear_trk;
  logic      accept;

  logic signed [IW-1:0] integ;
  logic                 clamp_hi;
  logic                 clamp_lo;

  logic [KP_WIDTH-1:0] kp_sel;
  logic [KI_WIDTH-1:0] ki_sel;
  logic signed [31:0]  e_s;
  logic signed [31:0]  kp_s;
  logic signed [31:0]  ki_s;
  logic signed [31:0]  p_term;
  logic signed [31:0]  i_raw;
  logic signed [31:0]  i_upd;
  logic signed [31:0]  sum_f;
  logic signed [31:0]  code;
  logic                windup;
  logic [DCO_CC_WIDTH-1:0] cc_nxt;
  logic                hi_nxt;
  logic                lo_nxt;

  assign accept  = enable_i && error_valid_i && (state != IDLE);
  assign state_o = state;

  lock_detector #(
    .ERROR_WIDTH  (ERROR_WIDTH),
    .LOCK_THRESH  (LOCK_THRESH),
    .LOCK_COUNT   (LOCK_COUNT),
    .UNLOCK_COUNT (UNLOCK_COUNT)
  ) u_lock (
    .clk      (gen_clk_i),
    .rst_n    (reset_n_i),
    .enable   (enable_i),
    .hold     (hold_i),
    .sample   (accept),
    .error    (error_i),
    .state    (state),
    .locked   (locked_o),
    .gear_trk (gear_trk)
  );

  always_comb begin
    kp_sel = gear_trk ? KP_TRK : KP_ACQ;
    ki_sel = gear_trk ? KI_TRK : KI_ACQ;
    e_s    = 32'(error_i);
    kp_s   = 32'(kp_sel);
    ki_s   = 32'(ki_sel);
    p_term = (kp_s * e_s) >>> KP_FRAC_WIDTH;
    i_raw  = sat_s32(32'(integ) + ki_s * e_s, MID_F);
    // no integration further into a rail the output already hit
    windup = (clamp_hi && (e_s > 0)) || (clamp_lo && (e_s < 0));
    i_upd  = (hold_i || windup) ? 32'(integ) : i_raw;
    sum_f  = MID_F + (p_term <<< FW) + i_upd;
  end

`ifdef GEAR_SHIFT_LOOP_FILTER_DITHER_EN
  logic [FW-1:0] dacc;
  logic [FW:0]   dsum;

  assign dsum = {1'b0, dacc} + {1'b0, sum_f[FW-1:0]};
  assign code = (sum_f >>> FW) + (dsum[FW] ? 32'sd1 : 32'sd0);

  always_ff @(posedge gen_clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      dacc <= '0;
    else if (!enable_i || state == IDLE)
      dacc <= '0;
    else if (accept)
      dacc <= dsum[FW-1:0];
  end
`else
  assign code = sum_f >>> FW;
`endif

  always_comb begin
    cc_nxt = DCO_CC_WIDTH'(code);
    hi_nxt = 1'b0;
    lo_nxt = 1'b0;
    if (code > CC_MAX) begin
      cc_nxt = DCO_CC_WIDTH'(CC_MAX);
      hi_nxt = 1'b1;
    end else if (code < 0) begin
      cc_nxt = '0;
      lo_nxt = 1'b1;
    end
  end

  always_ff @(posedge gen_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      integ          <= '0;
      clamp_hi       <= 1'b0;
      clamp_lo       <= 1'b0;
      dco_cc_o       <= MID_CC;
      dco_cc_valid_o <= 1'b0;
    end else if (!enable_i || state == IDLE) begin
      integ          <= '0;
      clamp_hi       <= 1'b0;
      clamp_lo       <= 1'b0;
      dco_cc_o       <= MID_CC;
      dco_cc_valid_o <= 1'b0;
    end else if (accept) begin
      integ          <= IW'(i_upd);
      clamp_hi       <= hi_nxt;
      clamp_lo       <= lo_nxt;
      dco_cc_o       <= cc_nxt;
      dco_cc_valid_o <= 1'b1;
    end else begin
      dco_cc_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gear_shift_loop_filter.sv
// Directed self-checking bench for gear_shift_loop_filter.
// Expected codes are hand-derived from the PI fixed-point arithmetic.
module tb_gear_shift_loop_filter;

  logic              gen_clk_i = 1'b0;
  logic              reset_n_i = 1'b0;
  logic              enable_i = 1'b0;
  logic              hold_i = 1'b0;
  logic signed [7:0] error_i = '0;
  logic              error_valid_i = 1'b0;
  logic [8:0]        dco_cc_o;
  logic              dco_cc_valid_o;
  logic [1:0]        state_o;
  logic              locked_o;

  int checks = 0;
  int failures = 0;

  always #5 gen_clk_i = ~gen_clk_i;

  gear_shift_loop_filter dut (
    .gen_clk_i      (gen_clk_i),
    .reset_n_i      (reset_n_i),
    .enable_i       (enable_i),
    .hold_i         (hold_i),
    .error_i        (error_i),
    .error_valid_i  (error_valid_i),
    .dco_cc_o       (dco_cc_o),
    .dco_cc_valid_o (dco_cc_valid_o),
    .state_o        (state_o),
    .locked_o       (locked_o)
  );

  task automatic do_reset();
    reset_n_i = 1'b0;
    enable_i = 1'b0;
    hold_i = 1'b0;
    error_valid_i = 1'b0;
    error_i = '0;
    @(posedge gen_clk_i); #1;
    reset_n_i = 1'b1;
    @(posedge gen_clk_i); #1;
  endtask

  task automatic start();
    enable_i = 1'b1;
    @(posedge gen_clk_i); #1;
  endtask

  task automatic send(input logic signed [7:0] e);
    error_i = e;
    error_valid_i = 1'b1;
    @(posedge gen_clk_i); #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dco_cc_o !== 9'd256 || dco_cc_valid_o !== 1'b0 ||
        state_o !== 2'd0 || locked_o !== 1'b0) begin
      failures++;
      $display("FAIL reset cc=%0d v=%0b st=%0d lk=%0b req 256/0/0/0",
               dco_cc_o, dco_cc_valid_o, state_o, locked_o);
    end
    start();
    checks++;
    if (state_o !== 2'd1 || dco_cc_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL enable_to_acq st=%0d v=%0b req 1/0",
               state_o, dco_cc_valid_o);
    end
    send(8'sd10);
    error_valid_i = 1'b0;
    #2 reset_n_i = 1'b0;
    #1;
    checks++;
    if (dco_cc_o !== 9'd256 || state_o !== 2'd0 ||
        dco_cc_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL async_reset cc=%0d st=%0d v=%0b req 256/0/0",
               dco_cc_o, state_o, dco_cc_valid_o);
    end
    @(posedge gen_clk_i); #1;
    reset_n_i = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    start();
    send(8'sd10);
    checks++;
    if (dco_cc_o !== 9'd267 || dco_cc_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL basic_s1 cc=%0d v=%0b req 267/1",
               dco_cc_o, dco_cc_valid_o);
    end
    send(8'sd10);
    checks++;
    if (dco_cc_o !== 9'd268 || dco_cc_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL basic_s2 cc=%0d v=%0b req 268/1",
               dco_cc_o, dco_cc_valid_o);
    end
    error_valid_i = 1'b0;
    @(posedge gen_clk_i); #1;
    checks++;
    if (dco_cc_o !== 9'd268 || dco_cc_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL basic_novalid cc=%0d v=%0b req 268/0",
               dco_cc_o, dco_cc_valid_o);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    start();
    for (int i = 0; i < 8; i++) send(8'sd127);
    checks++;
    if (dco_cc_o !== 9'd510) begin
      failures++;
      $display("FAIL sat_s8 cc=%0d req 510", dco_cc_o);
    end
    send(8'sd127);
    checks++;
    if (dco_cc_o !== 9'd511) begin
      failures++;
      $display("FAIL sat_s9 cc=%0d req 511", dco_cc_o);
    end
    send(8'sd127);
    send(8'sd127);
    checks++;
    if (dco_cc_o !== 9'd511) begin
      failures++;
      $display("FAIL sat_hold cc=%0d req 511", dco_cc_o);
    end
    send(-8'sd1);
    checks++;
    if (dco_cc_o !== 9'd397) begin
      failures++;
      $display("FAIL antiwindup cc=%0d req 397", dco_cc_o);
    end
  endtask

  task automatic test_lock();
    do_reset();
    start();
    for (int i = 0; i < 15; i++) send(8'sd0);
    checks++;
    if (state_o !== 2'd1 || dco_cc_o !== 9'd256) begin
      failures++;
      $display("FAIL lock_acq15 st=%0d cc=%0d req 1/256",
               state_o, dco_cc_o);
    end
    send(8'sd0);
    checks++;
    if (state_o !== 2'd2 || locked_o !== 1'b0) begin
      failures++;
      $display("FAIL lock_track st=%0d lk=%0b req 2/0",
               state_o, locked_o);
    end
    for (int i = 0; i < 16; i++) send(8'sd0);
    checks++;
    if (state_o !== 2'd3 || locked_o !== 1'b1) begin
      failures++;
      $display("FAIL lock_locked st=%0d lk=%0b req 3/1",
               state_o, locked_o);
    end
    send(8'sd20);
    checks++;
    if (dco_cc_o !== 9'd266) begin
      failures++;
      $display("FAIL lock_trk_gain cc=%0d req 266", dco_cc_o);
    end
    send(8'sd20);
    send(8'sd20);
    checks++;
    if (state_o !== 2'd3 || locked_o !== 1'b1) begin
      failures++;
      $display("FAIL lock_miss3 st=%0d lk=%0b req 3/1",
               state_o, locked_o);
    end
    send(8'sd20);
    checks++;
    if (state_o !== 2'd1 || locked_o !== 1'b0 ||
        dco_cc_o !== 9'd268) begin
      failures++;
      $display("FAIL unlock st=%0d lk=%0b cc=%0d req 1/0/268",
               state_o, locked_o, dco_cc_o);
    end
  endtask

  task automatic test_track_miss();
    do_reset();
    start();
    for (int i = 0; i < 16; i++) send(8'sd0);
    for (int i = 0; i < 15; i++) send((i % 2 == 0) ? 8'sd2 : -8'sd2);
    send(8'sd3);
    for (int i = 0; i < 15; i++) send((i % 2 == 0) ? -8'sd2 : 8'sd2);
    checks++;
    if (state_o !== 2'd2 || locked_o !== 1'b0) begin
      failures++;
      $display("FAIL track_miss st=%0d lk=%0b req 2/0",
               state_o, locked_o);
    end
    send(8'sd0);
    checks++;
    if (state_o !== 2'd3 || locked_o !== 1'b1) begin
      failures++;
      $display("FAIL track_relock st=%0d lk=%0b req 3/1",
               state_o, locked_o);
    end
  endtask

  task automatic test_hold();
    do_reset();
    start();
    send(8'sd10);
    send(8'sd10);
    hold_i = 1'b1;
    send(8'sd10);
    send(8'sd10);
    checks++;
    if (dco_cc_o !== 9'd268 || dco_cc_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL hold_freeze cc=%0d v=%0b req 268/1",
               dco_cc_o, dco_cc_valid_o);
    end
    send(-8'sd10);
    checks++;
    if (dco_cc_o !== 9'd248) begin
      failures++;
      $display("FAIL hold_pterm cc=%0d req 248", dco_cc_o);
    end
    hold_i = 1'b0;
    send(8'sd10);
    checks++;
    if (dco_cc_o !== 9'd269) begin
      failures++;
      $display("FAIL hold_resume cc=%0d req 269", dco_cc_o);
    end
    hold_i = 1'b1;
    enable_i = 1'b0;
    @(posedge gen_clk_i); #1;
    checks++;
    if (dco_cc_o !== 9'd256 || state_o !== 2'd0 ||
        dco_cc_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL disable cc=%0d st=%0d v=%0b req 256/0/0",
               dco_cc_o, state_o, dco_cc_valid_o);
    end
    hold_i = 1'b0;
    enable_i = 1'b1;
    @(posedge gen_clk_i); #1;
    checks++;
    if (state_o !== 2'd1 || dco_cc_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL reenable st=%0d v=%0b req 1/0",
               state_o, dco_cc_valid_o);
    end
    send(8'sd10);
    checks++;
    if (dco_cc_o !== 9'd267) begin
      failures++;
      $display("FAIL integ_cleared cc=%0d req 267", dco_cc_o);
    end
  endtask

  task automatic test_fraction();
    int total;
    int repeats;
    logic [8:0] prev;
    do_reset();
    start();
    send(8'sd4);
    prev = dco_cc_o;
    total = 0;
    repeats = 0;
    for (int i = 0; i < 64; i++) begin
      send(8'sd0);
      total += int'(dco_cc_o);
      if (i > 0 && dco_cc_o == prev) repeats++;
      prev = dco_cc_o;
    end
`ifdef GEAR_SHIFT_LOOP_FILTER_DITHER_EN
    checks++;
    if (total !== 16416) begin
      failures++;
      $display("FAIL dither_mean sum=%0d req 16416", total);
    end
    checks++;
    if (repeats !== 0) begin
      failures++;
      $display("FAIL dither_alt repeats=%0d req 0", repeats);
    end
`else
    checks++;
    if (total !== 16384) begin
      failures++;
      $display("FAIL trunc_sum sum=%0d req 16384", total);
    end
    checks++;
    if (repeats !== 63) begin
      failures++;
      $display("FAIL trunc_flat repeats=%0d req 63", repeats);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_lock();
    test_track_miss();
    test_hold();
    test_fraction();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
